// File: rtl/vvp_dot.sv
// Vector-vector dot product of one weight row and one data vector with
// four bipolar/unipolar element encodings and an optionally pipelined adder tree.
module vvp_dot #(
    parameter int n  = 64,
    parameter int pr = 0,
    localparam int a = $clog2(n)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [n-1:0]        W,
    input  logic [n-1:0]        D,
    output logic signed [a+1:0] S
);

    localparam int m  = 1 << a;
    localparam int sw = a + 2;

    localparam logic signed [sw-1:0] pos_one = sw'(1);
    localparam logic signed [sw-1:0] neg_one = '1;

    // Boundary j (after tree level j) holds a register when the even spread of
    // pr stages over a+1 boundaries steps there; the last boundary always does.
    function automatic bit regd(input int j);
        return ((j + 1) * pr) / (a + 1) != (j * pr) / (a + 1);
    endfunction

    function automatic logic signed [sw-1:0] elem(input logic [1:0] md,
                                                   input logic w, input logic d);
        case (md)
            2'b00:   elem = (w == d) ? pos_one : neg_one;
            2'b01:   elem = d ? (w ? pos_one : neg_one) : '0;
            2'b10:   elem = w ? (d ? pos_one : neg_one) : '0;
            default: elem = (w & d) ? pos_one : '0;
        endcase
    endfunction

    for (genvar j = 0; j <= a; j++) begin : lvl
        localparam int e = m >> j;
        logic signed [sw-1:0] c [e];
        logic signed [sw-1:0] q [e];

        if (j == 0) begin : leaf
            // Mode is consumed here, so it travels with its data implicitly.
            for (genvar i = 0; i < e; i++) begin : el
                if (i < n) begin : act
                    assign c[i] = elem(mode, W[i], D[i]);
                end else begin : pad
                    assign c[i] = '0;
                end
            end
        end else begin : sum
            for (genvar i = 0; i < e; i++) begin : add
                assign c[i] = lvl[j-1].q[2*i] + lvl[j-1].q[2*i+1];
            end
        end

        if (regd(j)) begin : stg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '{default: '0};
                end else begin
                    q <= c;
                end
            end
        end else begin : thru
            always_comb q = c;
        end
    end

    if (pr == 0) begin : comb_only
        logic unused_clk;
        assign unused_clk = clk ^ rst_n;
    end

    assign S = lvl[a].q[0];

endmodule

// File: tb/tb_vvp_dot.sv
// Directed and streamed checks of vvp_dot for n=64 (pr=0 and pr=2) and an
// exhaustive sweep of n=8 with pr=0.
module tb_vvp_dot;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [63:0]       W = '0;
    logic [63:0]       D = '0;
    logic [1:0]        mode8 = 2'b00;
    logic [7:0]        W8 = '0;
    logic [7:0]        D8 = '0;
    logic signed [7:0] S0;
    logic signed [7:0] S2;
    logic signed [4:0] S8;

    int checks = 0;
    int errors = 0;
    logic signed [7:0] expq [$];

    always #5 clk = ~clk;

    vvp_dot #(.n(64), .pr(0)) u_c64 (.clk(clk), .rst_n(rst_n), .mode(mode), .W(W), .D(D), .S(S0));
    vvp_dot #(.n(64), .pr(2)) u_p64 (.clk(clk), .rst_n(rst_n), .mode(mode), .W(W), .D(D), .S(S2));
    vvp_dot #(.n(8),  .pr(0)) u_c8  (.clk(clk), .rst_n(rst_n), .mode(mode8), .W(W8), .D(D8), .S(S8));

    function automatic int model(input logic [1:0] md, input logic [63:0] w,
                                 input logic [63:0] d, input int nn);
        logic [63:0] msk;
        msk = (nn == 64) ? '1 : ((64'd1 << nn) - 64'd1);
        case (md)
            2'b00:   return 2 * $countones(~(w ^ d) & msk) - nn;
            2'b01:   return $countones(w & d & msk) - $countones(~w & d & msk);
            2'b10:   return $countones(w & d & msk) - $countones(w & ~d & msk);
            default: return $countones(w & d & msk);
        endcase
    endfunction

    task automatic chk64(input string name, input logic [1:0] md, input logic [63:0] w,
                         input logic [63:0] d, input int req);
        logic signed [7:0] e;
        mode = md; W = w; D = d;
        #1;
        e = 8'(req);
        checks++;
        if (S0 !== e) begin
            errors++;
            $display("FAIL %s: S=%0d expected %0d", name, S0, e);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mode = 2'b11; W = '1; D = '1;
        @(posedge clk); #1;
        checks++;
        if (S2 !== 8'sd0) begin
            errors++;
            $display("FAIL reset_pipe: S=%0d expected 0", S2);
        end
        checks++;
        if (S0 !== 8'sd64) begin
            errors++;
            $display("FAIL reset_comb: S=%0d expected 64", S0);
        end
    endtask

    task automatic test_bipolar;
        chk64("bb_half",   2'b00, 64'h0, 64'h5555_5555_5555_5555, 0);
        chk64("bb_allagr", 2'b00, 64'h0, 64'h0, 64);
        chk64("bb_alldis", 2'b00, 64'h0, '1, -64);
        chk64("bb_one",    2'b00, 64'h1, 64'h0, 62);
    endtask

    task automatic test_unipolar;
        chk64("uu_full",  2'b11, '1, '1, 64);
        chk64("uu_16",    2'b11, 64'hFFFF_0000_0000_0000, '1, 16);
        chk64("uu_zero",  2'b11, 64'h0, '1, 0);
        chk64("uu_and",   2'b11, 64'hF0F0, 64'hFF00, 4);
    endtask

    task automatic test_mixed;
        chk64("bu_neg",   2'b01, 64'h0, '1, -64);
        chk64("bu_zero",  2'b01, 64'h0, 64'h0, 0);
        chk64("bu_mix",   2'b01, 64'h00FF, 64'h0FFF, 4);
        chk64("ub_neg",   2'b10, '1, 64'h0, -64);
        chk64("ub_zero",  2'b10, 64'h0, 64'h1234_5678_9ABC_DEF0, 0);
        chk64("ub_mix",   2'b10, 64'h0FFF, 64'h00FF, 4);
    endtask

    task automatic step_stream(input int cycles);
        logic [63:0] w, d;
        logic [1:0]  md;
        logic signed [7:0] e;
        for (int i = 0; i < cycles; i++) begin
            w = {$urandom, $urandom};
            d = {$urandom, $urandom};
            md = (i % 3 == 0) ? ~mode : 2'($urandom_range(0, 3));
            mode = md; W = w; D = d;
            expq.push_back(8'(model(md, w, d, 64)));
            @(negedge clk);
            e = expq.pop_front();
            checks++;
            if (S2 !== e) begin
                errors++;
                $display("FAIL pipe_stream[%0d]: S=%0d expected %0d", i, S2, e);
            end
        end
    endtask

    task automatic test_pipeline;
        @(negedge clk);
        rst_n = 1'b1;
        expq.delete();
        expq.push_back(8'sd0);
        step_stream(60);
    endtask

    task automatic test_reset_midstream;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (S2 !== 8'sd0) begin
            errors++;
            $display("FAIL midreset_async: S=%0d expected 0", S2);
        end
        @(negedge clk);
        checks++;
        if (S2 !== 8'sd0) begin
            errors++;
            $display("FAIL midreset_hold: S=%0d expected 0", S2);
        end
        rst_n = 1'b1;
        expq.delete();
        expq.push_back(8'sd0);
        checks++;
        if (S2 !== 8'sd0) begin
            errors++;
            $display("FAIL midreset_release: S=%0d expected 0", S2);
        end
        step_stream(40);
    endtask

    task automatic test_exhaustive_n8;
        logic signed [4:0] e;
        logic [7:0] wv, dv;
        checks++;
        if ($bits(S8) != 5) begin
            errors++;
            $display("FAIL n8_width: bits=%0d expected 5", $bits(S8));
        end
        for (int md = 0; md < 4; md++) begin
            for (int w = 0; w < 256; w++) begin
                for (int d = 0; d < 256; d++) begin
                    wv = 8'(w); dv = 8'(d);
                    mode8 = 2'(md); W8 = wv; D8 = dv;
                    #1;
                    e = 5'(model(2'(md), {56'd0, wv}, {56'd0, dv}, 8));
                    checks++;
                    if (S8 !== e) begin
                        errors++;
                        $display("FAIL n8_sweep m=%0d W=%02h D=%02h: S=%0d expected %0d",
                                 md, wv, dv, S8, e);
                    end
                end
            end
        end
        mode8 = 2'b00; W8 = 8'h00; D8 = 8'hFF; #1;
        checks++;
        if (S8 !== 5'b11000) begin
            errors++;
            $display("FAIL n8_min: S=%b expected 11000", S8);
        end
        mode8 = 2'b11; W8 = 8'hFF; D8 = 8'hFF; #1;
        checks++;
        if (S8 !== 5'b01000) begin
            errors++;
            $display("FAIL n8_max: S=%b expected 01000", S8);
        end
    endtask

    initial begin
        test_reset();
        test_bipolar();
        test_unipolar();
        test_mixed();
        test_pipeline();
        test_reset_midstream();
        test_exhaustive_n8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
